// File: rtl/csr_wb_queue.sv
// Writeback buffer between the CSR unit and the shared writeback bus: an in-order
// FIFO of CSR results with valid/ready output, rename throttling and flush.
module csr_wb_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_valid,
  input  logic        csr_error,
  input  logic [4:0]  csr_ecause,
  input  logic [6:0]  csr_robid,
  input  logic [5:0]  csr_rd,
  input  logic [31:0] csr_result,
  input  logic        rob_flush,
  input  logic        wb_ready,
  output logic        wb_valid,
  output logic        wb_error,
  output logic [4:0]  wb_ecause,
  output logic [6:0]  wb_robid,
  output logic [5:0]  wb_rd,
  output logic [31:0] wb_result,
  output logic        csrq_stall,
  output logic        csrq_overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  logic [50:0]   mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW:0]   count;
  logic          pop;
  logic          room;
  logic          push;

  // A pop on the same edge frees a slot, so a full queue can still accept.
  always_comb begin
    pop  = (count != '0) && wb_ready;
    room = (count != FULL) || pop;
    push = csr_valid && room;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      csrq_overflow <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i[AW-1:0]] <= '0;
    end else if (rob_flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[tail] <= {csr_error, csr_ecause, csr_robid, csr_rd, csr_result};
        tail      <= tail + 1'b1;
      end
      if (pop) head <= head + 1'b1;
      if (csr_valid && !room) csrq_overflow <= 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Stall one entry early: one result may already be in flight when rename sees it.
  assign csrq_stall = (count >= FULL - 1'b1);
  assign wb_valid   = (count != '0);
  assign {wb_error, wb_ecause, wb_robid, wb_rd, wb_result} = mem[head];

endmodule

// File: tb/tb_csr_wb_queue.sv
// Self-checking bench for csr_wb_queue: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_csr_wb_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        csr_valid;
  logic        csr_error;
  logic [4:0]  csr_ecause;
  logic [6:0]  csr_robid;
  logic [5:0]  csr_rd;
  logic [31:0] csr_result;
  logic        rob_flush;
  logic        wb_ready;
  logic        wb_valid;
  logic        wb_error;
  logic [4:0]  wb_ecause;
  logic [6:0]  wb_robid;
  logic [5:0]  wb_rd;
  logic [31:0] wb_result;
  logic        csrq_stall;
  logic        csrq_overflow;

  int checks = 0;
  int errors = 0;

  logic [50:0] mq[$];
  bit          m_ovf;

  csr_wb_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .csr_valid(csr_valid), .csr_error(csr_error), .csr_ecause(csr_ecause),
    .csr_robid(csr_robid), .csr_rd(csr_rd), .csr_result(csr_result),
    .rob_flush(rob_flush), .wb_ready(wb_ready),
    .wb_valid(wb_valid), .wb_error(wb_error), .wb_ecause(wb_ecause),
    .wb_robid(wb_robid), .wb_rd(wb_rd), .wb_result(wb_result),
    .csrq_stall(csrq_stall), .csrq_overflow(csrq_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 1'b0;
  endtask

  // Reference behaviour at a rising edge, from the current input values.
  task automatic model_edge();
    bit do_pop;
    bit has_room;
    if (!rst) begin
      model_reset();
    end else if (rob_flush) begin
      mq.delete();
    end else begin
      do_pop   = (mq.size() != 0) && wb_ready;
      has_room = (mq.size() < DEPTH) || do_pop;
      if (do_pop) void'(mq.pop_front());
      if (csr_valid) begin
        if (has_room) mq.push_back({csr_error, csr_ecause, csr_robid, csr_rd, csr_result});
        else m_ovf = 1'b1;
      end
    end
  endtask

  task automatic compare();
    chk("wb_valid", 64'(wb_valid), 64'(mq.size() != 0));
    if (mq.size() != 0)
      chk("payload", 64'({wb_error, wb_ecause, wb_robid, wb_rd, wb_result}), 64'(mq[0]));
    chk("stall", 64'(csrq_stall), 64'(mq.size() >= DEPTH - 1));
    chk("overflow", 64'(csrq_overflow), 64'(m_ovf));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic drive(input bit v, input bit [6:0] id, input bit rdy, input bit fl);
    csr_valid  = v;
    csr_robid  = id;
    wb_ready   = rdy;
    rob_flush  = fl;
    csr_error  = 1'($urandom_range(0, 1));
    csr_ecause = 5'($urandom);
    csr_rd     = 6'($urandom);
    csr_result = $urandom;
  endtask

  initial begin
    int exp_id[3];
    bit exp_st[3];
    int got[$];
    int sent;
    bit v;
    bit rdy;

    rst = 1'b0;
    drive(0, 0, 0, 0);
    model_reset();
    #12;
    chk("rst_valid", 64'(wb_valid), 64'd0);
    chk("rst_payload", 64'({wb_error, wb_ecause, wb_robid, wb_rd, wb_result}), 64'd0);
    chk("rst_stall", 64'(csrq_stall), 64'd0);
    chk("rst_overflow", 64'(csrq_overflow), 64'd0);
    #1 rst = 1'b1;

    // Single pass
    drive(1, 7'd5, 1, 0);
    csr_rd = 6'd9; csr_result = 32'hDEADBEEF; csr_error = 1'b0; csr_ecause = 5'd0;
    cycle();
    chk("single_valid", 64'(wb_valid), 64'd1);
    chk("single_robid", 64'(wb_robid), 64'd5);
    chk("single_rd", 64'(wb_rd), 64'd9);
    chk("single_result", 64'(wb_result), 64'hDEADBEEF);
    drive(0, 0, 1, 0);
    cycle();
    chk("single_drained", 64'(wb_valid), 64'd0);

    // Back-pressure and fill
    for (int i = 1; i <= 3; i++) begin
      drive(1, 7'(i), 0, 0);
      cycle();
      if (i == 2) chk("fill_stall_at2", 64'(csrq_stall), 64'd0);
    end
    chk("fill_stall_at3", 64'(csrq_stall), 64'd1);
    drive(1, 7'd4, 0, 0);
    cycle();
    chk("fill_no_ovf", 64'(csrq_overflow), 64'd0);
    chk("fill_head", 64'(wb_robid), 64'd1);
    exp_id = '{2, 3, 4};
    exp_st = '{1, 0, 0};
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 0);
      cycle();
      chk("drain_robid", 64'(wb_robid), 64'(exp_id[i]));
      chk("drain_stall", 64'(csrq_stall), 64'(exp_st[i]));
    end
    drive(0, 0, 1, 0);
    cycle();
    chk("drain_empty", 64'(wb_valid), 64'd0);

    // Full with simultaneous enqueue and pop
    for (int i = 10; i <= 13; i++) begin
      drive(1, 7'(i), 0, 0);
      cycle();
    end
    drive(1, 7'd7, 1, 0);
    cycle();
    chk("full_swap_stall", 64'(csrq_stall), 64'd1);
    chk("full_swap_head", 64'(wb_robid), 64'd11);
    chk("full_swap_ovf", 64'(csrq_overflow), 64'd0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 0);
      cycle();
    end
    chk("full_swap_last", 64'(wb_robid), 64'd7);
    drive(0, 0, 1, 0);
    cycle();
    chk("full_swap_empty", 64'(wb_valid), 64'd0);

    // Flush with a same-cycle enqueue
    for (int i = 40; i <= 42; i++) begin
      drive(1, 7'(i), 0, 0);
      cycle();
    end
    drive(1, 7'd50, 0, 1);
    cycle();
    chk("flush_valid", 64'(wb_valid), 64'd0);
    chk("flush_stall", 64'(csrq_stall), 64'd0);
    chk("flush_ovf", 64'(csrq_overflow), 64'd0);
    drive(1, 7'd51, 0, 0);
    cycle();
    chk("flush_fresh_valid", 64'(wb_valid), 64'd1);
    chk("flush_fresh_robid", 64'(wb_robid), 64'd51);
    drive(0, 0, 1, 0);
    cycle();

    // Pointer wrap with toggling ready
    sent = 0;
    for (int c = 0; c < 100; c++) begin
      rdy = (c % 2 == 0);
      v   = (sent < 10) && !csrq_stall;
      if (wb_valid && rdy) got.push_back(int'(wb_robid));
      drive(v, 7'(sent), rdy, 0);
      if (v) sent++;
      cycle();
      if (sent == 10 && !wb_valid) break;
    end
    chk("wrap_count", 64'(got.size()), 64'd10);
    for (int i = 0; i < got.size() && i < 10; i++) chk("wrap_order", 64'(got[i]), 64'(i));
    chk("wrap_ovf", 64'(csrq_overflow), 64'd0);

    // Overflow
    for (int i = 20; i <= 23; i++) begin
      drive(1, 7'(i), 0, 0);
      cycle();
    end
    drive(1, 7'd8, 0, 0);
    cycle();
    chk("ovf_set", 64'(csrq_overflow), 64'd1);
    chk("ovf_head", 64'(wb_robid), 64'd20);
    for (int i = 0; i < 4; i++) begin
      chk("ovf_not_dropped_id", 64'(wb_robid == 7'd8), 64'd0);
      drive(0, 0, 1, 0);
      cycle();
    end
    drive(0, 0, 0, 1);
    cycle();
    chk("ovf_sticky_flush", 64'(csrq_overflow), 64'd1);

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      v = ($urandom_range(0, 3) != 0) && (!csrq_stall || $urandom_range(0, 7) == 0);
      drive(v, 7'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
      cycle();
    end

    // Asynchronous reset mid-operation
    drive(1, 7'd60, 0, 0);
    cycle();
    drive(1, 7'd61, 0, 0);
    cycle();
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("async_valid", 64'(wb_valid), 64'd0);
    chk("async_payload", 64'({wb_error, wb_ecause, wb_robid, wb_rd, wb_result}), 64'd0);
    chk("async_stall", 64'(csrq_stall), 64'd0);
    chk("async_ovf", 64'(csrq_overflow), 64'd0);
    drive(0, 0, 0, 0);
    #1 rst = 1'b1;
    drive(1, 7'd70, 1, 0);
    cycle();
    chk("post_rst_robid", 64'(wb_robid), 64'd70);
    drive(0, 0, 1, 0);
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
